sprite_eval: RTL and testbench
==============================

Name: sprite_eval

Overview:
- Per-scanline sprite evaluation engine.
- Scans the 64-entry primary OAM and copies up to 8 in-range sprites (4 bytes each) into a 32-byte secondary OAM (oam2) owned by this block.
- Raises sprite overflow and a sprite-0-next-line flag.
- Writer side of oam2: the per-sprite units read oam2 through the read port during fetch cycles 257-320.

Parameters:
- NSPR, 8, max sprites per line; oam2 depth = 4*NSPR bytes.
- NOAM, 64, primary OAM sprite entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- rend  in  1  rendering enabled
- cycle  in  9  PPU dot 0-340
- scanline  in  9  PPU line 0-261
- tall  in  1  8x16 sprite mode
- ovf_clr  in  1  clear overflow flag (pre-render line, cycle 1)
- oam_addr  out  8  primary OAM read address
- oam_data  in  8  primary OAM data; valid the cycle after oam_addr
- oam2_raddr  in  5  oam2 read address
- oam2_rdata  out  8  oam2[oam2_raddr], combinational
- spr_count  out  4  sprites copied for next line, 0-8
- spr0_next  out  1  sprite 0 is in oam2 for next line
- overflow  out  1  sticky sprite overflow

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; all oam2 bytes=0xFF.
  - oam_addr=0, spr_count=0, spr0_next=0, overflow=0.
  - Reset overrides any operation in progress.
- Active only when rend=1 and scanline<=239. Otherwise state goes to IDLE next edge, no oam2 writes, outputs hold.
- States: IDLE, CLEAR, SCAN, COPY, FULL, DONE.
- IDLE -> CLEAR at cycle 1.
- CLEAR, cycles 1-64:
  - On each even cycle c, oam2[c/2-1] <= 0xFF.
  - At cycle 64: n=0, m=0, found=0, s0=0; -> SCAN.
- Access pacing, cycles 65-256:
  - Odd cycle: oam_addr = 4n+m.
  - Following even cycle: oam_data is valid and the state acts on it.
- SCAN (m=0):
  - diff = scanline - oam_data, 9-bit unsigned. In range iff diff < 8 (tall=0) or diff < 16 (tall=1).
  - In range: oam2[4*found] <= Y; set s0 if n=0; m=1; -> COPY.
  - Out of range: n++.
- COPY:
  - Each pair writes oam2[4*found+m] <= oam_data; m++.
  - After m=3: found++, m=0, n++.
  - If found==NSPR -> FULL, else -> SCAN.
  - Attribute bytes are copied unmodified (no masking).
- FULL:
  - Reads byte 0 of sprite n each pair.
  - In range: overflow <= 1; -> DONE. Else n++.
- Wrap: n reaching NOAM (6-bit overflow) from any state -> DONE. No further oam2 writes.
- End of window: cycle 256 even edge forces DONE whatever the state. A partially copied sprite remains in oam2 but is not counted.
- DONE/IDLE, cycle 257 edge: spr_count <= found; spr0_next <= s0.
- overflow is cleared only by ovf_clr or reset. If ovf_clr and a set event occur on the same edge, the set wins.
- rend falling mid-evaluation: abandon; oam2 keeps the bytes written so far; spr_count/spr0_next are not updated on that line.
- oam2_rdata is a pure combinational read and is valid in all states.

Optional Feature:
- Macro: SPRITE_OVF_BUG_EN.
- Defined: in FULL, on each out-of-range result both n and m increment (m wraps 3->0 without carry). In-range reads then walk 3 further bytes as in COPY before DONE. This reproduces the 2C02 diagonal-scan false/missed overflow.
- Undefined: FULL compares only byte 0 of each sprite, so overflow is exact.

Test Plan:
- Reset: hold rst_n=0 2 cycles -> oam2 all 0xFF, spr_count=0, overflow=0, spr0_next=0, oam_addr=0.
- All Y=0xEF, scanline 100, tall=0 -> oam2 all 0xFF after cycle 64; spr_count=0 at cycle 257.
- Sprite 0 = {Y=10, 0x21, 0x03, 0x40}, scanline 12 -> oam2[0..3]={10,0x21,0x03,0x40}, spr0_next=1, spr_count=1.
- Sprite 5 Y=100, tall=1: scanline 115 -> copied, spr_count=1; scanline 116 -> not copied, spr_count=0.
- Sprites 0-8 Y=50, scanline 52, macro off -> spr_count=8, overflow=1; ovf_clr pulse -> overflow=0.
- rend dropped at cycle 100 after sprite 0 copied -> oam2[0..3] retains sprite 0 bytes; spr_count keeps previous line value; IDLE by next edge.

Source files
------------

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: clears and fills the 32-byte secondary OAM (oam2) for the next line.
// Define SPRITE_OVF_BUG_EN to reproduce the 2C02 diagonal overflow scan once oam2 is full.
module sprite_eval #(
    parameter int NSPR = 8,
    parameter int NOAM = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rend,
    input  logic [8:0] cycle,
    input  logic [8:0] scanline,
    input  logic       tall,
    input  logic       ovf_clr,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    input  logic [4:0] oam2_raddr,
    output logic [7:0] oam2_rdata,
    output logic [3:0] spr_count,
    output logic       spr0_next,
    output logic       overflow
);

    localparam int OAW = $clog2(4 * NSPR);
    localparam int NW  = $clog2(NOAM);
    localparam int FW  = $clog2(NSPR + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, COPY, FULL, DONE} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [1:0]      m_q, m_d;
    logic [FW-1:0]   found_q, found_d;
    logic            s0_q, s0_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      oam_addr_q, oam_addr_d;
    logic [3:0]      spr_count_q, spr_count_d;
    logic            spr0_next_q, spr0_next_d;
    logic [7:0]      oam2_q [4*NSPR];

`ifdef SPRITE_OVF_BUG_EN
    logic            walk_q, walk_d;
    logic [1:0]      walk_cnt_q, walk_cnt_d;
`endif

    logic            wr_en;
    logic [OAW-1:0]  wr_idx;
    logic [7:0]      wr_data;

    logic            active;
    logic            scan_phase;
    logic            odd_slot;
    logic            even_slot;
    logic [8:0]      diff;
    logic            in_range;
    logic            n_last;
    logic            found_last;

    assign active     = rend && (scanline <= 9'd239);
    assign scan_phase = (state_q == SCAN) || (state_q == COPY) || (state_q == FULL);
    assign odd_slot   = cycle[0] && (cycle >= 9'd65) && (cycle <= 9'd255);
    assign even_slot  = !cycle[0] && (cycle >= 9'd66) && (cycle <= 9'd256);
    // Unsigned wrap makes sprites below the line (Y > scanline) land far out of range.
    assign diff       = scanline - {1'b0, oam_data};
    assign in_range   = tall ? (diff < 9'd16) : (diff < 9'd8);
    assign n_last     = (n_q == NW'(NOAM - 1));
    assign found_last = (found_q == FW'(NSPR - 1));

    assign oam_addr   = oam_addr_q;
    assign oam2_rdata = oam2_q[oam2_raddr];
    assign spr_count  = spr_count_q;
    assign spr0_next  = spr0_next_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            m_q         <= '0;
            found_q     <= '0;
            s0_q        <= 1'b0;
            overflow_q  <= 1'b0;
            oam_addr_q  <= '0;
            spr_count_q <= '0;
            spr0_next_q <= 1'b0;
`ifdef SPRITE_OVF_BUG_EN
            walk_q      <= 1'b0;
            walk_cnt_q  <= '0;
`endif
            // NOTE: oam2 must read 0xFF straight out of reset, so it is a reset flop array, not a RAM.
            for (int i = 0; i < 4 * NSPR; i++) begin
                oam2_q[i] <= 8'hFF;
            end
        end else begin
            // NOTE: all state updates use non-blocking assignments so every flop sees pre-edge values.
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            found_q     <= found_d;
            s0_q        <= s0_d;
            overflow_q  <= overflow_d;
            oam_addr_q  <= oam_addr_d;
            spr_count_q <= spr_count_d;
            spr0_next_q <= spr0_next_d;
`ifdef SPRITE_OVF_BUG_EN
            walk_q      <= walk_d;
            walk_cnt_q  <= walk_cnt_d;
`endif
            if (wr_en) begin
                oam2_q[wr_idx] <= wr_data;
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cycle == 9'd1) state_d = CLEAR;
                CLEAR: if (cycle == 9'd64) state_d = SCAN;
                SCAN: begin
                    if (even_slot) begin
                        if (in_range)    state_d = COPY;
                        else if (n_last) state_d = DONE;
                    end
                end
                COPY: begin
                    if (even_slot && (m_q == 2'd3)) begin
                        if (n_last)          state_d = DONE;
                        else if (found_last) state_d = FULL;
                        else                 state_d = SCAN;
                    end
                end
                FULL: begin
                    if (even_slot) begin
`ifdef SPRITE_OVF_BUG_EN
                        if (walk_q) begin
                            if (walk_cnt_q == 2'd2) state_d = DONE;
                        end else if (!in_range && n_last) begin
                            state_d = DONE;
                        end
`else
                        if (in_range || n_last) state_d = DONE;
`endif
                    end
                end
                DONE:    if (cycle == 9'd257) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (scan_phase && (cycle == 9'd256)) state_d = DONE;
        end
    end

    always_comb begin
        n_d         = n_q;
        m_d         = m_q;
        found_d     = found_q;
        s0_d        = s0_q;
        overflow_d  = ovf_clr ? 1'b0 : overflow_q;
        oam_addr_d  = oam_addr_q;
        spr_count_d = spr_count_q;
        spr0_next_d = spr0_next_q;
        wr_en       = 1'b0;
        wr_idx      = {found_q[OAW-3:0], m_q};
        wr_data     = oam_data;
`ifdef SPRITE_OVF_BUG_EN
        walk_d      = walk_q;
        walk_cnt_d  = walk_cnt_q;
`endif
        if (active) begin
            case (state_q)
                CLEAR: begin
                    if (!cycle[0]) begin
                        wr_en   = 1'b1;
                        wr_idx  = cycle[OAW:1] - OAW'(1);
                        wr_data = 8'hFF;
                    end
                    if (cycle == 9'd64) begin
                        n_d     = '0;
                        m_d     = '0;
                        found_d = '0;
                        s0_d    = 1'b0;
`ifdef SPRITE_OVF_BUG_EN
                        walk_d  = 1'b0;
`endif
                    end
                end
                SCAN, COPY, FULL: begin
                    if (odd_slot) oam_addr_d = 8'({n_q, m_q});
                    if (even_slot) begin
                        case (state_q)
                            SCAN: begin
                                if (in_range) begin
                                    wr_en = 1'b1;
                                    m_d   = 2'd1;
                                    if (n_q == '0) s0_d = 1'b1;
                                end else begin
                                    n_d = n_q + NW'(1);
                                end
                            end
                            COPY: begin
                                wr_en = 1'b1;
                                m_d   = m_q + 2'd1;
                                if (m_q == 2'd3) begin
                                    found_d = found_q + FW'(1);
                                    n_d     = n_q + NW'(1);
                                end
                            end
                            default: begin
`ifdef SPRITE_OVF_BUG_EN
                                // Hardware quirk: m advances alongside n, so later checks read non-Y bytes.
                                if (walk_q) begin
                                    m_d        = m_q + 2'd1;
                                    walk_cnt_d = walk_cnt_q + 2'd1;
                                    if (m_q == 2'd3) n_d = n_q + NW'(1);
                                end else if (in_range) begin
                                    overflow_d = 1'b1;
                                    walk_d     = 1'b1;
                                    walk_cnt_d = '0;
                                    m_d        = m_q + 2'd1;
                                    if (m_q == 2'd3) n_d = n_q + NW'(1);
                                end else begin
                                    n_d = n_q + NW'(1);
                                    m_d = m_q + 2'd1;
                                end
`else
                                if (in_range) overflow_d = 1'b1;
                                else          n_d = n_q + NW'(1);
`endif
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (cycle == 9'd257) begin
                        spr_count_d = 4'(found_q);
                        spr0_next_d = s0_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_eval.sv
// Self-checking bench for sprite_eval: directed test-plan lines plus random lines,
// checked every cycle against a per-line schedule derived from the evaluation rules.
module tb_sprite_eval;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rend;
    logic [8:0] cycle;
    logic [8:0] scanline;
    logic       tall;
    logic       ovf_clr;
    logic [7:0] oam_addr;
    logic [7:0] oam_data;
    logic [4:0] oam2_raddr;
    logic [7:0] oam2_rdata;
    logic [3:0] spr_count;
    logic       spr0_next;
    logic       overflow;

    logic [7:0] oam_mem [256];

    always #5 clk = ~clk;
    assign oam_data = oam_mem[oam_addr];

    sprite_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rend       (rend),
        .cycle      (cycle),
        .scanline   (scanline),
        .tall       (tall),
        .ovf_clr    (ovf_clr),
        .oam_addr   (oam_addr),
        .oam_data   (oam_data),
        .oam2_raddr (oam2_raddr),
        .oam2_rdata (oam2_rdata),
        .spr_count  (spr_count),
        .spr0_next  (spr0_next),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected DUT-visible state.
    logic [7:0] e_oam2 [32];
    logic [7:0] e_addr;
    logic [3:0] e_cnt;
    logic       e_s0;
    logic       e_ovf;
    bit         line_ok;

    // Schedule of the current line: addresses per access pair, oam2 writes, results.
    logic [7:0] s_addr [96];
    int         s_np;
    int         w_cyc [32];
    logic [4:0] w_idx [32];
    logic [7:0] w_val [32];
    int         s_nw;
    logic [3:0] s_found;
    bit         s_s0;
    int         s_ovf_cyc;

    function automatic bit in_rng(input logic [7:0] y, input int sl, input bit tl);
        int d;
        d = (sl - int'(y)) & 'h1FF;
        return tl ? (d < 16) : (d < 8);
    endfunction

    // Pair p reads at odd cycle 65+2p and acts at the following even cycle 66+2p.
    task automatic build_sched(input int sl, input bit tl);
        bit hit;
        s_np = 0; s_nw = 0; s_found = 0; s_s0 = 0; s_ovf_cyc = -1;
        for (int n = 0; n < 64; n++) begin
            hit = in_rng(oam_mem[4*n], sl, tl);
            if (s_found < 8) begin
                if (hit) begin
                    for (int m = 0; m < 4; m++) begin
                        s_addr[s_np] = 8'(4*n + m);
                        w_cyc[s_nw]  = 66 + 2*s_np;
                        w_idx[s_nw]  = 5'(4*s_found + m);
                        w_val[s_nw]  = oam_mem[4*n + m];
                        s_nw++;
                        s_np++;
                    end
                    if (n == 0) s_s0 = 1;
                    s_found++;
                end else begin
                    s_addr[s_np] = 8'(4*n);
                    s_np++;
                end
            end else begin
                s_addr[s_np] = 8'(4*n);
                s_np++;
                if (hit) begin
                    s_ovf_cyc = 66 + 2*(s_np - 1);
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        int  c;
        bit  act;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) e_oam2[i] = 8'hFF;
            e_addr = 0; e_cnt = 0; e_s0 = 0; e_ovf = 0; line_ok = 0;
        end else begin
            c   = int'(cycle);
            act = rend && (scanline <= 239);
            if (ovf_clr) e_ovf = 0;
            if (c == 1) line_ok = act;
            else if (!act) line_ok = 0;
            if (line_ok) begin
                if (c >= 2 && c <= 64 && (c % 2 == 0)) e_oam2[c/2 - 1] = 8'hFF;
                if (c >= 65 && c <= 255 && (c % 2 == 1) && ((c - 65)/2 < s_np))
                    e_addr = s_addr[(c - 65)/2];
                for (int i = 0; i < s_nw; i++)
                    if (w_cyc[i] == c) e_oam2[w_idx[i]] = w_val[i];
                if (c == s_ovf_cyc) e_ovf = 1;
                if (c == 257) begin
                    e_cnt = s_found;
                    e_s0  = s_s0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("cyc oam_addr",   oam_addr,   e_addr);
            check("cyc spr_count",  spr_count,  e_cnt);
            check("cyc spr0_next",  spr0_next,  e_s0);
            check("cyc overflow",   overflow,   e_ovf);
            check("cyc oam2_rdata", oam2_rdata, e_oam2[oam2_raddr]);
        end
    end

    task automatic run_line(input int sl, input bit tl, input int drop, input int resume, input bit clr);
        for (int c = 0; c <= 340; c++) begin
            @(posedge clk);
            #1;
            cycle      = 9'(c);
            scanline   = 9'(sl);
            tall       = tl;
            rend       = !(c >= drop && c < resume);
            ovf_clr    = clr && (c == 1);
            oam2_raddr = 5'($urandom);
            if (c == 0) build_sched(sl, tl);
        end
    endtask

    task automatic peek(input int idx, input logic [7:0] exp, input string name);
        @(posedge clk);
        #1;
        oam2_raddr = 5'(idx);
        @(negedge clk);
        #1;
        check(name, oam2_rdata, exp);
    endtask

    task automatic set_bg();
        for (int i = 0; i < 256; i++) oam_mem[i] = ((i % 4) == 0) ? 8'hEF : 8'($urandom);
    endtask

    initial begin
        int sl;
        bit tl;
        int drop;
        int resume;
        rst_n = 0; rend = 0; cycle = 9'd340; scanline = 0; tall = 0; ovf_clr = 0; oam2_raddr = 0;
        set_bg();
        @(posedge clk);
        checking = 1;
        @(posedge clk);
        #1;
        rst_n = 1;

        // Reset state
        check("rst spr_count", spr_count, 0);
        check("rst overflow",  overflow,  0);
        check("rst spr0_next", spr0_next, 0);
        check("rst oam_addr",  oam_addr,  0);
        for (int i = 0; i < 32; i++) peek(i, 8'hFF, "rst oam2");

        // Sprite 0 in range on scanline 12
        set_bg();
        oam_mem[0] = 8'd10; oam_mem[1] = 8'h21; oam_mem[2] = 8'h03; oam_mem[3] = 8'h40;
        run_line(12, 0, 999, 999, 0);
        check("s0 spr_count", spr_count, 1);
        check("s0 spr0_next", spr0_next, 1);
        peek(0, 8'd10, "s0 oam2[0]");
        peek(1, 8'h21, "s0 oam2[1]");
        peek(2, 8'h03, "s0 oam2[2]");
        peek(3, 8'h40, "s0 oam2[3]");
        peek(4, 8'hFF, "s0 oam2[4]");

        // Nothing in range: oam2 fully cleared
        set_bg();
        run_line(100, 0, 999, 999, 0);
        check("none spr_count", spr_count, 0);
        check("none spr0_next", spr0_next, 0);
        for (int i = 0; i < 32; i++) peek(i, 8'hFF, "none oam2");

        // 8x16 boundary for sprite 5 at Y=100
        set_bg();
        oam_mem[20] = 8'd100;
        run_line(115, 1, 999, 999, 0);
        check("tall15 spr_count", spr_count, 1);
        check("tall15 spr0_next", spr0_next, 0);
        peek(0, 8'd100, "tall15 oam2[0]");
        run_line(116, 1, 999, 999, 0);
        check("tall16 spr_count", spr_count, 0);

        // Nine sprites in range: eight copied, overflow set, then cleared on pre-render
        set_bg();
        for (int n = 0; n < 9; n++) oam_mem[4*n] = 8'd50;
        run_line(52, 0, 999, 999, 0);
        check("full spr_count", spr_count, 8);
        check("full overflow",  overflow,  1);
        check("full spr0_next", spr0_next, 1);
        peek(28, 8'd50, "full oam2[28]");
        run_line(261, 0, 999, 999, 1);
        check("clr overflow",  overflow,  0);
        check("clr spr_count", spr_count, 8);

        // rend dropped at cycle 100, restored at 120: line abandoned
        set_bg();
        oam_mem[0] = 8'd30; oam_mem[1] = 8'hAA; oam_mem[2] = 8'hBB; oam_mem[3] = 8'hCC;
        run_line(31, 0, 100, 120, 0);
        check("drop spr_count", spr_count, 8);
        check("drop spr0_next", spr0_next, 1);
        check("drop oam_addr",  oam_addr,  56);
        peek(0, 8'd30, "drop oam2[0]");
        peek(1, 8'hAA, "drop oam2[1]");
        peek(2, 8'hBB, "drop oam2[2]");
        peek(3, 8'hCC, "drop oam2[3]");
        peek(4, 8'hFF, "drop oam2[4]");

        // Randomized lines
        for (int k = 0; k < 25; k++) begin
            sl = $urandom_range(0, 261);
            tl = 1'($urandom);
            for (int i = 0; i < 256; i++) oam_mem[i] = 8'($urandom);
            if ($urandom_range(0, 2) != 0)
                for (int n = 0; n < 64; n++)
                    if ($urandom_range(0, 3) == 0) oam_mem[4*n] = 8'(sl - $urandom_range(0, 17));
            drop = 999; resume = 999;
            if ($urandom_range(0, 4) == 0) begin
                drop   = $urandom_range(2, 300);
                resume = drop + $urandom_range(1, 40);
            end
            run_line(sl, tl, drop, resume, $urandom_range(0, 3) == 0);
        end

        run_line(261, 0, 999, 999, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
